// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation codes, the FSM state encoding and the counter sizing helper.
package mcycle_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Ceiling log2, used to size the iteration counter (holds WIDTH-1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mcycle_addsub.sv
// N-bit adder/subtractor with carry out, shared by the multiply and divide steps.
// With sub=1 the carry out is 1 exactly when a >= b (unsigned, no borrow).
module mcycle_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_x;

    assign b_x         = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{N{1'b0}}, sub};

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: MUL, MULH, DIV, REM on signed or unsigned operands.
// Optional MCYCLE_EARLY_OUT_EN skips the iteration for zero multiply operands or a zero divisor.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [TAG_W-1:0] TagIn,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done,
    output logic [TAG_W-1:0] TagOut
);

    localparam int CNT_W = clog2(WIDTH);

    state_e             state;
    op_e                op_q;
    logic               signed_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opa_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q;    // product high half or partial remainder
    logic [WIDTH-1:0]   lo_q;    // multiplier/product low half or dividend/quotient
    logic [CNT_W-1:0]   count_q;

    logic               is_div;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic               early_out;

    logic [WIDTH:0]     as_a;
    logic [WIDTH:0]     as_b;
    logic [WIDTH:0]     as_sum;
    logic               as_cout;

    logic [WIDTH:0]     mul_acc;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_res;

    assign is_div = op_q[1];
    assign sign1  = signed_q & lo_q[WIDTH-1];
    assign sign2  = signed_q & opa_q[WIDTH-1];
    assign abs1   = sign1 ? -lo_q : lo_q;
    assign abs2   = sign2 ? -opa_q : opa_q;

`ifdef MCYCLE_EARLY_OUT_EN
    assign early_out = is_div ? (opa_q == '0) : ((lo_q == '0) || (opa_q == '0));
`else
    assign early_out = 1'b0;
`endif

    // Multiply adds the multiplicand to the high half; divide subtracts the divisor
    // from the left-shifted partial remainder.
    assign as_a = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    assign as_b = {1'b0, opa_q};

    mcycle_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (is_div),
        .sum (as_sum),
        .cout(as_cout)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mul_acc = lo_q[0] ? as_sum : {1'b0, hi_q};
        hi_next = mul_acc[WIDTH:1];
        lo_next = {mul_acc[0], lo_q[WIDTH-1:1]};
        if (is_div) begin
            hi_next = as_cout ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
            lo_next = {lo_q[WIDTH-2:0], as_cout};
        end
    end

    assign prod_neg = -{hi_q, lo_q};

    always_comb begin
        fix_res = lo_q;
        case (op_q)
            OP_MUL:  fix_res = neg_q ? prod_neg[WIDTH-1:0] : lo_q;
            OP_MULH: fix_res = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : hi_q;
            OP_DIV:  fix_res = neg_q ? -lo_q : lo_q;
            OP_REM:  fix_res = neg_q ? -hi_q : hi_q;
            default: fix_res = lo_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            Result   <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            TagOut   <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_q     <= op_e'(Op);
                        signed_q <= Signed;
                        lo_q     <= Operand1;
                        opa_q    <= Operand2;
                        TagOut   <= TagIn;
                        Busy     <= 1'b1;
                        state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    hi_q    <= '0;
                    count_q <= CNT_W'(WIDTH - 1);
                    if (is_div) begin
                        lo_q  <= abs1;
                        opa_q <= abs2;
                    end else begin
                        lo_q  <= abs2;
                        opa_q <= abs1;
                    end
                    // A zero divisor must yield an all-ones quotient, so it is never negated.
                    if (op_q == OP_DIV && opa_q == '0) begin
                        neg_q <= 1'b0;
                    end else if (op_q == OP_REM) begin
                        neg_q <= sign1;
                    end else begin
                        neg_q <= sign1 ^ sign2;
                    end
                    if (early_out) begin
                        // Preload the architectural answer and let FIX pass it through.
                        neg_q <= 1'b0;
                        if (is_div) begin
                            hi_q <= lo_q;
                            lo_q <= '1;
                        end else begin
                            lo_q <= '0;
                        end
                        state <= ST_FIX;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hi_q <= hi_next;
                    lo_q <= lo_next;
                    if (count_q == '0) begin
                        state <= ST_FIX;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    Result <= fix_res;
                    Busy   <= 1'b0;
                    Done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: stimulus pushes expected results, a monitor checks each Done.
// Expected values are hand-computed; latency follows MCYCLE_EARLY_OUT_EN when defined.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int LAT   = WIDTH + 2;
`ifdef MCYCLE_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             Reset;
    logic             Start;
    logic [1:0]       Op;
    logic             Signed;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [TAG_W-1:0] TagIn;
    logic [WIDTH-1:0] Result;
    logic             Busy;
    logic             Done;
    logic [TAG_W-1:0] TagOut;

    mcycle_unit #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .Signed  (Signed),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .TagIn   (TagIn),
        .Result  (Result),
        .Busy    (Busy),
        .Done    (Done),
        .TagOut  (TagOut)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int latency(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        bit zero;
        zero = op[1] ? (b == '0) : ((a == '0) || (b == '0));
        return (EARLY && zero) ? 2 : LAT;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!Reset && Done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got Done=1 TagOut=%0d expected no Done (t=%0t)",
                         TagOut, $time);
            end else begin
                e = sb.pop_front();
                check("result", Result, e.res);
                check("tag_out", 32'(TagOut), 32'(e.tag));
                check("busy_in_done", 32'(Busy), 32'd0);
                check("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Waits for IDLE, pulses Start for one cycle, then scrambles the inputs.
    task automatic issue(input logic [1:0] op, input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [WIDTH-1:0] res, input bit expect_done);
        int   waited;
        exp_t e;
        waited = 0;
        while ((Busy || Done) && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (Busy || Done) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got Busy=%0b Done=%0b expected idle within 200 cycles",
                     Busy, Done);
            return;
        end
        Op       = op;
        Signed   = sgn;
        Operand1 = a;
        Operand2 = b;
        TagIn    = tag;
        Start    = 1'b1;
        if (expect_done) begin
            e.res = res;
            e.tag = tag;
            e.due = cyc + 1 + latency(op, a, b);
            sb.push_back(e);
        end
        @(negedge CLK);
        Start    = 1'b0;
        Op       = 2'($urandom);
        Signed   = 1'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
        TagIn    = 4'($urandom);
    endtask

    initial begin
        int w;
        Reset    = 1'b1;
        Start    = 1'b0;
        Op       = OP_MUL;
        Signed   = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        TagIn    = '0;
        repeat (2) @(negedge CLK);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_result", Result, 32'd0);
        check("reset_tag", 32'(TagOut), 32'd0);
        Reset = 1'b0;
        @(negedge CLK);

        // op, signed, operand1, operand2, tag, expected result
        issue(OP_MUL,  1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 4'd5,  32'hFFFF_FFEB, 1'b1);
        issue(OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1,  32'hFFFF_FFFE, 1'b1);
        issue(OP_MULH, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2,  32'h0000_0000, 1'b1);
        issue(OP_MUL,  1'b0, 32'h0001_0000, 32'h0001_0000, 4'd12, 32'h0000_0000, 1'b1);
        issue(OP_MULH, 1'b0, 32'h0001_0000, 32'h0001_0000, 4'd13, 32'h0000_0001, 1'b1);
        issue(OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 4'd3,  32'hFFFF_FFFD, 1'b1);
        issue(OP_REM,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 4'd4,  32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV,  1'b0, 32'd100,       32'd7,         4'd6,  32'd14,        1'b1);
        issue(OP_REM,  1'b0, 32'd100,       32'd7,         4'd7,  32'd2,         1'b1);
        issue(OP_DIV,  1'b0, 32'h1234_5678, 32'h0000_0000, 4'd8,  32'hFFFF_FFFF, 1'b1);
        issue(OP_REM,  1'b0, 32'h1234_5678, 32'h0000_0000, 4'd9,  32'h1234_5678, 1'b1);
        issue(OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 4'd14, 32'hFFFF_FFFF, 1'b1);
        issue(OP_REM,  1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 4'd15, 32'hFFFF_FFF9, 1'b1);
        issue(OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h8000_0000, 1'b1);
        issue(OP_REM,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h0000_0000, 1'b1);
        issue(OP_MUL,  1'b0, 32'h0000_0000, 32'h0000_0005, 4'd0,  32'h0000_0000, 1'b1);

        // Start pulses during RUN and during the DONE cycle must be ignored.
        issue(OP_MUL, 1'b0, 32'd6, 32'd7, 4'd1, 32'd42, 1'b1);
        repeat (10) @(negedge CLK);
        Start = 1'b1;
        TagIn = 4'd15;
        @(negedge CLK);
        Start = 1'b0;
        w = 0;
        while (!Done && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check("done_seen_before_ignore", 32'(Done), 32'd1);
        Start = 1'b1;
        TagIn = 4'd14;
        @(negedge CLK);
        Start = 1'b0;
        check("start_in_done_ignored", 32'(Busy), 32'd0);
        repeat (LAT + 6) @(negedge CLK);

        // Reset in the middle of RUN aborts the operation without a Done.
        issue(OP_DIV, 1'b0, 32'd100, 32'd7, 4'd3, 32'd0, 1'b0);
        repeat (10) @(negedge CLK);
        #1 Reset = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_result", Result, 32'd0);
        check("abort_tag", 32'(TagOut), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        issue(OP_MUL, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 4'd9, 32'hFFFF_FFFA, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the single-mode shift-add/restore datapath.
- Adds the following over the previous generation:
  - four operations: MUL low, MUL high, DIV, REM
  - signed and unsigned operands
  - explicit Done pulse
  - parametrised destination tag
- Sits beside the ALU in the execute stage. The pipeline stalls on Busy and writes Result to register TagOut when Done pulses.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- TAG_W, 4, width of destination-register tag carried with the operation.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0 and Done=0.
- Op  in  2  00=MUL (low WIDTH bits), 01=MULH (high WIDTH bits), 10=DIV (quotient), 11=REM (remainder).
- Signed  in  1  1=two's-complement operands, 0=unsigned.
- Operand1  in  WIDTH  multiplicand / dividend.
- Operand2  in  WIDTH  multiplier / divisor.
- TagIn  in  TAG_W  destination tag, captured with Start.
- Result  out  WIDTH  registered result; valid while Done=1, holds last value otherwise.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle completion pulse.
- TagOut  out  TAG_W  tag of the operation in flight / just completed.

Behaviour:
- Reset: async. All outputs and internal registers go to 0 and the state goes to IDLE. Reset mid-operation aborts it; no Done is produced.
- States: IDLE, PREP, RUN, FIX, DONE.
  - IDLE: Start=1 at edge E0 captures Op, Signed, operands and TagIn, then goes to PREP.
  - PREP, 1 cycle:
    - If Signed, take absolute values of both operands.
    - Record the result sign: XOR of operand signs for MUL/MULH/DIV; dividend sign for REM.
    - Load count = WIDTH-1.
  - RUN, WIDTH cycles, one bit per cycle:
    - Multiply: shift-add on the 2*WIDTH product register.
    - Divide: restoring shift-subtract on a WIDTH+1 partial remainder.
    - count decrements each cycle; leave RUN when count=0.
  - FIX, 1 cycle: negate the selected half if the recorded sign=1. MULH signed uses the full 2*WIDTH negation.
  - DONE, 1 cycle: Done=1 and Result valid, then return to IDLE.
- Latency: Done is high in the cycle after edge E0+WIDTH+2. Busy=1 from after E0 until the DONE state; Busy=0 while Done=1.
- Back-to-back: Start during DONE is ignored. The earliest new accept is the first IDLE cycle, so throughput is one operation per WIDTH+4 cycles.
- Start while Busy=1: ignored. The inputs do not need to be held after E0.
- Divide by zero (Operand2=0): RUN executes normally.
  - Result: quotient = all ones (unsigned) or -1 (signed).
  - Remainder = Operand1 unchanged.
  - FIX must not alter these results.
- Signed overflow, DIV/REM with Operand1 = most-negative and Operand2 = -1: quotient = most-negative, remainder = 0.
- MUL result is identical for Signed=0/1. MULH differs.
- TagOut updates at E0 and holds until the next accept.

Optional Feature:
- Macro: MCYCLE_EARLY_OUT_EN.
- Defined: in PREP, if either multiply operand is 0 or the divisor is 0, go directly to DONE with the architecturally defined result. Latency becomes 2 cycles; all other cases are unchanged.
- Undefined: latency is always WIDTH+2, with no data-dependent timing.

Decomposition:
- Package mcycle_pkg holds:
  - Op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM)
  - state encoding (ST_IDLE..ST_DONE)
  - a count-width function clog2(WIDTH)
- Sub-module mcycle_addsub: WIDTH+1 adder/subtractor (sub input, carry out), shared by the multiply and divide steps.

Test Plan (WIDTH=32, TAG_W=4):
- MUL, Signed=1, 0xFFFFFFFD x 0x00000007 (-3*7), TagIn=5 -> Done at cycle E0+34, Result=0xFFFFFFEB, TagOut=5, Busy low in Done cycle.
- MULH, Signed=0 vs 1, 0xFFFFFFFF x 0xFFFFFFFF -> unsigned Result=0xFFFFFFFE; signed Result=0x00000000.
- DIV/REM, Signed=1, -7 / 2 -> DIV=0xFFFFFFFD (-3); REM=0xFFFFFFFF (-1). Unsigned 100/7 -> 14 and 2.
- Divide by zero 0x12345678/0 -> DIV=0xFFFFFFFF, REM=0x12345678. Signed 0x80000000 / 0xFFFFFFFF -> DIV=0x80000000, REM=0.
- Start pulsed during RUN and in the DONE cycle -> ignored, a single Done only. Reset asserted mid-RUN -> Busy=Done=Result=0 immediately, then a new Start completes normally.
- With MCYCLE_EARLY_OUT_EN: MUL 0 x 5 -> Done at E0+2, Result=0. DIV x/0 -> Done at E0+2 with the divide-by-zero values.
